// File: rtl/hit_judge_if.sv
// Judge bus: timebase strobe, note arming and key levels going in;
// judgement code, track index and sticky overflow coming out.
interface hit_judge_if #(
  parameter int TRACKS = 6
) ();
  logic              Tick;
  logic [TRACKS-1:0] NoteArm;
  logic [TRACKS-1:0] Key;
  logic [2:0]        Msg;
  logic [2:0]        MsgTrack;
  logic              Overflow;

  // Stimulus side (game sequencer / testbench)
  modport master (
    output Tick, NoteArm, Key,
    input  Msg, MsgTrack, Overflow
  );

  // Judge side
  modport slave (
    input  Tick, NoteArm, Key,
    output Msg, MsgTrack, Overflow
  );
endinterface

// File: rtl/hit_judge.sv
// Per-track timing judge: one small FSM per track rates key presses against
// the note hit window, parks results in per-track pending slots, and a
// priority serialiser emits at most one judgement code per clock.
module hit_judge #(
  parameter int TRACKS   = 6,
  parameter int FAR_WIN  = 8,
  parameter int PURE_WIN = 3,
  parameter int CNT_W    = 5
) (
  input  logic        OriginalClk,
  input  logic        Rst_n,
  hit_judge_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * FAR_WIN);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(FAR_WIN);
  localparam logic [CNT_W-1:0] CNT_PURE = CNT_W'(PURE_WIN);

  localparam logic [1:0] CODE_LOST = 2'd1;
  localparam logic [1:0] CODE_FAR  = 2'd2;
  localparam logic [1:0] CODE_PURE = 2'd3;

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  logic [TRACKS-1:0] r_key_prev;
  logic [TRACKS-1:0] w_press;
  logic [TRACKS-1:0] w_res_valid;
  logic [1:0]        w_res_code [TRACKS];

  logic [TRACKS-1:0] r_slot_full;
  logic [1:0]        r_slot_code [TRACKS];
  logic [TRACKS-1:0] w_drain;
  logic              w_sel_valid;
  logic [2:0]        w_sel_idx;
  logic [1:0]        w_sel_code;
  logic              w_overwrite;

  logic [2:0]        r_msg;
  logic [2:0]        r_msg_track;
  logic              r_overflow;

  assign w_press = bus.Key & ~r_key_prev;

  // Key history for rising-edge detection
  always_ff @(posedge OriginalClk) begin
    if (!Rst_n) r_key_prev <= '0;
    else        r_key_prev <= bus.Key;
  end

  genvar gi;
  generate
    for (gi = 0; gi < TRACKS; gi++) begin : g_track
      state_t           r_state, w_state_next;
      logic [CNT_W-1:0] r_cnt, w_cnt_next;
      logic [CNT_W-1:0] w_dist;
      logic             w_vld;
      logic [1:0]       w_code;

      assign w_dist = (r_cnt >= CNT_MID) ? (r_cnt - CNT_MID) : (CNT_MID - r_cnt);

      // Next-state, window counter and judgement for this track
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_vld        = 1'b0;
        w_code       = 2'd0;
        case (r_state)
          S_IDLE: begin
            if (bus.NoteArm[gi]) begin
              w_state_next = S_ARMED;
              w_cnt_next   = '0;
            end
          end
          S_ARMED: begin
            if (w_press[gi]) begin
              // Press beats expiry and judges the current note even if a
              // new note arrives on the same clock.
              w_vld  = 1'b1;
              w_code = (w_dist <= CNT_PURE) ? CODE_PURE : CODE_FAR;
              if (bus.NoteArm[gi]) w_cnt_next = '0;
              else                 w_state_next = S_IDLE;
            end else if (bus.NoteArm[gi]) begin
              // A new note displaces the unanswered one.
              w_vld      = 1'b1;
              w_code     = CODE_LOST;
              w_cnt_next = '0;
            end else if (r_cnt == CNT_MAX) begin
              w_vld        = 1'b1;
              w_code       = CODE_LOST;
              w_state_next = S_IDLE;
            end else if (bus.Tick) begin
              // Never exceeds CNT_MAX: the branch above ends the note there.
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          default: w_state_next = S_IDLE;
        endcase
      end

      // Track state register
      always_ff @(posedge OriginalClk) begin
        if (!Rst_n) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      assign w_res_valid[gi] = w_vld;
      assign w_res_code[gi]  = w_code;

      // Pending slot: a new result always lands, even over a draining value
      always_ff @(posedge OriginalClk) begin
        if (!Rst_n) begin
          r_slot_full[gi] <= 1'b0;
          r_slot_code[gi] <= 2'd0;
        end else if (w_res_valid[gi]) begin
          r_slot_full[gi] <= 1'b1;
          r_slot_code[gi] <= w_res_code[gi];
        end else if (w_drain[gi]) begin
          r_slot_full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Pick the lowest-index full slot for output this clock
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = 3'd0;
    w_sel_code  = 2'd0;
    w_drain     = '0;
    for (int i = TRACKS - 1; i >= 0; i--) begin
      if (r_slot_full[i]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 3'(i);
        w_sel_code  = r_slot_code[i];
      end
    end
    if (w_sel_valid) w_drain[w_sel_idx] = 1'b1;
  end

  // A result only counts as lost if its slot holds a value not leaving now
  assign w_overwrite = |(w_res_valid & r_slot_full & ~w_drain);

  // Registered judgement output and sticky overflow flag
  always_ff @(posedge OriginalClk) begin
    if (!Rst_n) begin
      r_msg       <= 3'd0;
      r_msg_track <= 3'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_msg       <= w_sel_valid ? {1'b0, w_sel_code} : 3'd0;
      r_msg_track <= w_sel_valid ? w_sel_idx : 3'd0;
      r_overflow  <= r_overflow | w_overwrite;
    end
  end

  assign bus.Msg      = r_msg;
  assign bus.MsgTrack = r_msg_track;
  assign bus.Overflow = r_overflow;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hand-computed judgement codes, tracks,
// latencies and overflow behaviour.
module tb_hit_judge;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   nz_cnt;
  int   nz_snap;

  hit_judge_if #(.TRACKS(6)) bus ();

  hit_judge dut (
    .OriginalClk(clk),
    .Rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every clock on which a judgement is presented
  always @(negedge clk) begin
    if (bus.Msg != 3'd0) nz_cnt = nz_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [5:0] mask);
    bus.NoteArm = mask;
    cyc();
    bus.NoteArm = 6'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Tick = 1'b1;
      cyc();
      bus.Tick = 1'b0;
      cyc();
    end
  endtask

  task automatic wait_msg(input string tag, input int code, input int trk, input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.Msg == 3'd0 && n < budget);
    check_val({tag, "_msg"}, int'(bus.Msg), code);
    check_val({tag, "_trk"}, int'(bus.MsgTrack), trk);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    nz_cnt = 0;
    bus.Tick    = 1'b0;
    bus.NoteArm = 6'd0;
    bus.Key     = 6'd0;

    // 1: reset with inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Key     = (i % 2 == 0) ? 6'h3F : 6'h00;
      bus.NoteArm = (i % 2 == 0) ? 6'h15 : 6'h2A;
      bus.Tick    = 1'b1;
      cyc();
    end
    check_val("rst_msg", int'(bus.Msg), 0);
    check_val("rst_trk", int'(bus.MsgTrack), 0);
    check_val("rst_ovf", int'(bus.Overflow), 0);
    bus.Key = 6'd0; bus.NoteArm = 6'd0; bus.Tick = 1'b0;
    rst_n = 1'b1;
    cyc(); cyc();
    check_val("rst_after_msg", int'(bus.Msg), 0);

    // 2: pure hit on track 2, 2-clock latency, 1 clock wide
    arm(6'b000100);
    ticks(8);
    bus.Key = 6'b000100;
    cyc();
    check_val("t2_lat1", int'(bus.Msg), 0);
    bus.Key = 6'd0;
    cyc();
    check_val("t2_msg", int'(bus.Msg), 3);
    check_val("t2_trk", int'(bus.MsgTrack), 2);
    cyc();
    check_val("t2_gone", int'(bus.Msg), 0);

    // 3: far (d=4) then lost on expiry
    arm(6'b000001);
    ticks(4);
    bus.Key = 6'b000001;
    cyc();
    bus.Key = 6'd0;
    cyc();
    check_val("t3_far_msg", int'(bus.Msg), 2);
    check_val("t3_far_trk", int'(bus.MsgTrack), 0);
    arm(6'b000001);
    ticks(16);
    wait_msg("t3_lost", 1, 0, 6);

    // 4: held key gives no edge; press while idle gives nothing
    bus.Key = 6'b000010;
    cyc(); cyc();
    cyc();
    nz_snap = nz_cnt;
    arm(6'b000010);
    ticks(8);
    check_val("t4_held_quiet", nz_cnt - nz_snap, 0);
    bus.Key = 6'd0;
    ticks(8);
    wait_msg("t4_expire", 1, 1, 6);
    cyc();
    nz_snap = nz_cnt;
    bus.Key = 6'b010000;
    cyc();
    bus.Key = 6'd0;
    repeat (4) cyc();
    check_val("t4_idle_quiet", nz_cnt - nz_snap, 0);

    // 5: simultaneous pure presses on tracks 0,3,5
    arm(6'b101001);
    ticks(8);
    bus.Key = 6'b101001;
    cyc();
    bus.Key = 6'd0;
    cyc();
    check_val("t5_m0", int'(bus.Msg), 3);
    check_val("t5_k0", int'(bus.MsgTrack), 0);
    cyc();
    check_val("t5_m1", int'(bus.Msg), 3);
    check_val("t5_k1", int'(bus.MsgTrack), 3);
    cyc();
    check_val("t5_m2", int'(bus.Msg), 3);
    check_val("t5_k2", int'(bus.MsgTrack), 5);
    cyc();
    check_val("t5_end_msg", int'(bus.Msg), 0);
    check_val("t5_end_trk", int'(bus.MsgTrack), 0);

    // 6: re-arm on track 1 loses the first note, second judged normally
    nz_snap = nz_cnt;
    arm(6'b000010);
    ticks(5);
    arm(6'b000010);
    wait_msg("t6_lost", 1, 1, 4);
    ticks(8);
    bus.Key = 6'b000010;
    cyc();
    bus.Key = 6'd0;
    wait_msg("t6_pure", 3, 1, 4);
    cyc();
    check_val("t6_count", nz_cnt - nz_snap, 2);

    // Mid-window reset discards pending result and armed note
    arm(6'b000001);
    ticks(8);
    bus.Key = 6'b000001;
    cyc();
    bus.Key = 6'd0;
    rst_n = 1'b0;
    cyc();
    check_val("mrst_msg", int'(bus.Msg), 0);
    rst_n = 1'b1;
    nz_snap = nz_cnt;
    ticks(10);
    repeat (3) cyc();
    check_val("mrst_quiet", nz_cnt - nz_snap, 0);

    // Overflow: slot 5 refilled while lower slots hold the serialiser
    arm(6'b100111);
    ticks(8);
    bus.Key     = 6'b100111;
    bus.NoteArm = 6'b100000;
    cyc();
    check_val("ovf_pre", int'(bus.Overflow), 0);
    bus.NoteArm = 6'b100000;
    cyc();
    bus.NoteArm = 6'd0;
    bus.Key     = 6'd0;
    check_val("ovf_m0", int'(bus.Msg), 3);
    check_val("ovf_k0", int'(bus.MsgTrack), 0);
    check_val("ovf_set", int'(bus.Overflow), 1);
    cyc();
    check_val("ovf_k1", int'(bus.MsgTrack), 1);
    cyc();
    check_val("ovf_k2", int'(bus.MsgTrack), 2);
    cyc();
    check_val("ovf_m5", int'(bus.Msg), 1);
    check_val("ovf_k5", int'(bus.MsgTrack), 5);
    cyc();
    check_val("ovf_drained", int'(bus.Msg), 0);
    check_val("ovf_sticky", int'(bus.Overflow), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_val("ovf_clear", int'(bus.Overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
